// File: rtl/frame_update_scheduler.sv
// Sequences per-frame object updates during vertical blanking: one strobe per enabled
// slot in fixed order, waiting on each slot's done with a bounded timeout.
`timescale 1ns/1ps
module frame_update_scheduler #(
    parameter int N_SLOTS = 2,
    parameter int TIMEOUT = 1023,
    parameter int TW      = 10
) (
    input  logic               clck,
    input  logic               reset,
    input  logic               activeLine,
    input  logic [N_SLOTS-1:0] enable,
    input  logic [N_SLOTS-1:0] done,
    input  logic               clear_status,
    output logic [N_SLOTS-1:0] update,
    output logic               busy,
    output logic               frame_done,
    output logic [7:0]         frame_count,
    output logic               overrun,
    output logic [N_SLOTS-1:0] timeout_err
);

    localparam int SW = $clog2(N_SLOTS + 1);
    localparam logic [SW-1:0] END_SLOT  = SW'(N_SLOTS);
    localparam logic [SW-1:0] SLOT_ONE  = SW'(1);
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT);
    localparam logic [TW-1:0] TIMER_ONE = TW'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        STROBE = 2'd2,
        WAIT   = 2'd3
    } state_t;

    // One-hot select of the current slot; all-zero once the slot index passes the last slot.
    function automatic logic [N_SLOTS-1:0] slot_sel(input logic [SW-1:0] s);
        slot_sel = N_SLOTS'(1) << s;
    endfunction

    state_t               state_q, state_d;
    logic [SW-1:0]        slot_q, slot_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic                 act_q, act_d;
    logic [N_SLOTS-1:0]   update_q, update_d;
    logic                 busy_q, busy_d;
    logic                 frame_done_q, frame_done_d;
    logic [7:0]           frame_count_q, frame_count_d;
    logic                 overrun_q, overrun_d;
    logic [N_SLOTS-1:0]   timeout_err_q, timeout_err_d;

    logic                 blank_start_s;
    logic [N_SLOTS-1:0]   sel_s;
    logic                 abort_s;
    logic [N_SLOTS-1:0]   to_set_s;

    assign blank_start_s = act_q & ~activeLine;
    assign sel_s         = slot_sel(slot_q);

    // Next-state and output computation for the sequencer.
    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q;
        timer_d       = timer_q;
        act_d         = activeLine;
        update_d      = {N_SLOTS{1'b0}};
        frame_done_d  = 1'b0;
        frame_count_d = frame_count_q;
        abort_s       = 1'b0;
        to_set_s      = {N_SLOTS{1'b0}};

        case (state_q)
            IDLE: begin
                if (blank_start_s) begin
                    frame_count_d = frame_count_q + 8'd1;
                    slot_d        = {SW{1'b0}};
                    state_d       = SCAN;
                end else begin
                    state_d = IDLE;
                end
            end
            SCAN: begin
                if (activeLine) begin
                    abort_s = 1'b1;
                    state_d = IDLE;
                end else if (slot_q == END_SLOT) begin
                    frame_done_d = 1'b1;
                    state_d      = IDLE;
                end else if (|(enable & sel_s)) begin
                    update_d = sel_s;
                    state_d  = STROBE;
                end else begin
                    slot_d  = slot_q + SLOT_ONE;
                    state_d = SCAN;
                end
            end
            STROBE: begin
                timer_d = {TW{1'b0}};
                if (activeLine) begin
                    abort_s = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // Abort outranks both done and timeout on the same edge.
                if (activeLine) begin
                    abort_s = 1'b1;
                    state_d = IDLE;
                end else if (|(done & sel_s)) begin
                    slot_d  = slot_q + SLOT_ONE;
                    state_d = SCAN;
                end else if (timer_q == TIMER_MAX) begin
                    to_set_s = sel_s;
                    slot_d   = slot_q + SLOT_ONE;
                    state_d  = SCAN;
                end else begin
                    timer_d = timer_q + TIMER_ONE;
                    state_d = WAIT;
                end
            end
            default: begin
                state_d = IDLE;
                slot_d  = {SW{1'b0}};
                timer_d = {TW{1'b0}};
            end
        endcase

        busy_d = (state_d != IDLE);

        // Set events win over a concurrent clear.
        if (clear_status) begin
            overrun_d     = abort_s;
            timeout_err_d = to_set_s;
        end else begin
            overrun_d     = overrun_q | abort_s;
            timeout_err_d = timeout_err_q | to_set_s;
        end
    end

    // State and registered outputs; act_q resets high so no blank start is seen straight out of reset.
    always_ff @(posedge clck or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            slot_q        <= {SW{1'b0}};
            timer_q       <= {TW{1'b0}};
            act_q         <= 1'b1;
            update_q      <= {N_SLOTS{1'b0}};
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_count_q <= 8'd0;
            overrun_q     <= 1'b0;
            timeout_err_q <= {N_SLOTS{1'b0}};
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            timer_q       <= timer_d;
            act_q         <= act_d;
            update_q      <= update_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
            frame_count_q <= frame_count_d;
            overrun_q     <= overrun_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign update      = update_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign frame_count = frame_count_q;
    assign overrun     = overrun_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_frame_update_scheduler.sv
// Directed bench for frame_update_scheduler: vector table plus hand-written multi-cycle sequences.
`timescale 1ns/1ps
module tb_frame_update_scheduler;

    logic       clck = 1'b0;
    logic       reset = 1'b1;
    logic       activeLine = 1'b1;
    logic [1:0] enable = 2'b00;
    logic [1:0] done = 2'b00;
    logic       clear_status = 1'b0;
    logic [1:0] update;
    logic       busy;
    logic       frame_done;
    logic [7:0] frame_count;
    logic       overrun;
    logic [1:0] timeout_err;

    always #5 clck = ~clck;

    frame_update_scheduler #(.N_SLOTS(2), .TIMEOUT(15), .TW(4)) dut (
        .clck(clck), .reset(reset), .activeLine(activeLine), .enable(enable),
        .done(done), .clear_status(clear_status), .update(update), .busy(busy),
        .frame_done(frame_done), .frame_count(frame_count), .overrun(overrun),
        .timeout_err(timeout_err)
    );

    int checks = 0;
    int errors = 0;

    logic [14:0] outs;
    assign outs = {update, busy, frame_done, overrun, frame_count, timeout_err};

    typedef struct {
        logic       al;
        logic [1:0] en;
        logic [1:0] dn;
        logic       clr;
        logic [1:0] upd;
        logic       bsy;
        logic       fd;
        logic       ov;
        logic [7:0] fc;
        logic [1:0] te;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic al, input logic [1:0] en, input logic [1:0] dn,
                       input logic clr, input logic [1:0] upd, input logic bsy,
                       input logic fd, input logic ov, input logic [7:0] fc,
                       input logic [1:0] te);
        vec_t v;
        v.al = al; v.en = en; v.dn = dn; v.clr = clr; v.upd = upd;
        v.bsy = bsy; v.fd = fd; v.ov = ov; v.fc = fc; v.te = te;
        tv.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clck);
        #1;
    endtask

    // Update must stay one-hot and never repeat on consecutive cycles.
    logic [1:0] prev_upd = 2'b00;
    always @(negedge clck) begin
        if (update != 2'b00) begin
            checks++;
            if (!$onehot(update) || prev_upd != 2'b00) begin
                errors++;
                $display("FAIL upd_invariant actual=%b previous=%b", update, prev_upd);
            end
        end
        prev_upd = update;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int fd_cnt;
        int fd_total;

        // Two slots, slot 0 done after 4 cycles, slot 1 done already high
        add(1'b0, 2'b11, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 8'd1, 2'b00);
        add(1'b0, 2'b11, 2'b00, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 8'd1, 2'b00);
        add(1'b0, 2'b11, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 8'd1, 2'b00);
        add(1'b0, 2'b11, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 8'd1, 2'b00);
        add(1'b0, 2'b11, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 8'd1, 2'b00);
        add(1'b0, 2'b11, 2'b01, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 8'd1, 2'b00);
        add(1'b0, 2'b11, 2'b00, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 8'd1, 2'b00);
        add(1'b0, 2'b11, 2'b10, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 8'd1, 2'b00);
        add(1'b0, 2'b11, 2'b10, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 8'd1, 2'b00);
        add(1'b0, 2'b11, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 8'd1, 2'b00);
        add(1'b0, 2'b11, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 8'd1, 2'b00);
        // Slot 0 disabled
        add(1'b1, 2'b10, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 8'd1, 2'b00);
        add(1'b0, 2'b10, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 8'd2, 2'b00);
        add(1'b0, 2'b10, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 8'd2, 2'b00);
        add(1'b0, 2'b10, 2'b00, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 8'd2, 2'b00);
        add(1'b0, 2'b10, 2'b10, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 8'd2, 2'b00);
        add(1'b0, 2'b10, 2'b10, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 8'd2, 2'b00);
        add(1'b0, 2'b10, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 8'd2, 2'b00);
        add(1'b0, 2'b10, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 8'd2, 2'b00);
        // Abort in WAIT beats done and concurrent clear; later clear drops overrun
        add(1'b1, 2'b11, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 8'd2, 2'b00);
        add(1'b0, 2'b11, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 8'd3, 2'b00);
        add(1'b0, 2'b11, 2'b00, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 8'd3, 2'b00);
        add(1'b0, 2'b11, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 8'd3, 2'b00);
        add(1'b0, 2'b11, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 8'd3, 2'b00);
        add(1'b1, 2'b11, 2'b01, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 8'd3, 2'b00);
        add(1'b1, 2'b11, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 8'd3, 2'b00);
        add(1'b1, 2'b11, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 8'd3, 2'b00);
        add(1'b1, 2'b11, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 8'd3, 2'b00);
        // Abort in STROBE: the registered strobe still lasts exactly one cycle
        add(1'b0, 2'b11, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 8'd4, 2'b00);
        add(1'b0, 2'b11, 2'b00, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 8'd4, 2'b00);
        add(1'b1, 2'b11, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 8'd4, 2'b00);
        add(1'b1, 2'b11, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 8'd4, 2'b00);

        repeat (3) @(posedge clck);
        #1;
        reset = 1'b0;
        #1;
        chk("reset_state", 32'(outs), 32'd0);

        for (int i = 0; i < tv.size(); i++) begin
            activeLine   = tv[i].al;
            enable       = tv[i].en;
            done         = tv[i].dn;
            clear_status = tv[i].clr;
            tick();
            chk($sformatf("vec%0d", i), 32'(outs),
                32'({tv[i].upd, tv[i].bsy, tv[i].fd, tv[i].ov, tv[i].fc, tv[i].te}));
        end
        clear_status = 1'b0;

        // Timeout on both slots (TIMEOUT=15 -> 16 WAIT cycles per slot)
        activeLine = 1'b1; enable = 2'b11; done = 2'b00;
        tick();
        activeLine = 1'b0;
        n = 0;
        while (update !== 2'b01 && n < 6) begin tick(); n++; end
        chk("t4_upd0_latency", 32'(n), 32'd2);
        n = 0;
        do begin tick(); n++; end while (update !== 2'b10 && n < 40);
        chk("t4_upd1_gap", 32'(n), 32'd18);
        chk("t4_te_mid", 32'(timeout_err), 32'd1);
        fd_cnt = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (frame_done) fd_cnt++;
        end
        chk("t4_fd_count", 32'(fd_cnt), 32'd1);
        chk("t4_te_end", 32'(timeout_err), 32'd3);
        chk("t4_fc", 32'(frame_count), 32'd5);
        chk("t4_busy", 32'(busy), 32'd0);
        clear_status = 1'b1;
        tick();
        clear_status = 1'b0;
        chk("t4_te_clear", 32'(timeout_err), 32'd0);

        // Reset asserted between edges while waiting on slot 0
        activeLine = 1'b1; done = 2'b00;
        tick();
        activeLine = 1'b0;
        repeat (4) tick();
        chk("t1_busy_before", 32'(busy), 32'd1);
        #3;
        reset = 1'b1;
        #1;
        chk("t1_reset_async", 32'(outs), 32'd0);
        #2;
        reset = 1'b0;
        #1;
        chk("t1_release_upd", 32'(update), 32'd0);
        activeLine = 1'b1;
        tick();
        tick();
        chk("t1_after_release", 32'(outs), 32'd0);

        // 256 blanking intervals wrap frame_count
        enable = 2'b00;
        fd_total = 0;
        for (int i = 0; i < 256; i++) begin
            activeLine = 1'b1;
            tick();
            if (frame_done) fd_total++;
            activeLine = 1'b0;
            for (int k = 0; k < 8; k++) begin
                tick();
                if (frame_done) fd_total++;
            end
            chk($sformatf("t6_fc%0d", i), 32'(frame_count), 32'((i + 1) % 256));
        end
        chk("t6_wrap", 32'(frame_count), 32'd0);
        chk("t6_fd_total", 32'(fd_total), 32'd256);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
